// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU and the two-requester ALU arbiter:
//   - ALU operation-selector codes
//   - arbiter FSM state encoding
//   - requester ID type (0 = execute stage, 1 = branch/AGU)
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 32;
  localparam int ALU_SEL_WIDTH  = 4;

  localparam logic [ALU_SEL_WIDTH-1:0] ALU_ADD       = 4'd0;
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_SUB       = 4'd1;
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_AND       = 4'd2;
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_OR        = 4'd3;
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_XOR       = 4'd4;
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_SLL       = 4'd5;
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_SLR       = 4'd6;
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_SLT       = 4'd7;
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_SLTU      = 4'd8;
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_SRA       = 4'd9;
  localparam logic [ALU_SEL_WIDTH-1:0] ALU_OPERAND_B = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//   Purely combinational 32-bit ALU.
//   Ports:
//     operand_a, operand_b : operands
//     sel                  : operation selector (see alu_pkg); undefined codes
//                            return 0
//     result               : operation result
//   Shifts use operand_b[4:0]; SLT/SLTU return a zero-extended 1-bit flag.
// -----------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  logic signed [DATA_WIDTH-1:0] a_s;
  logic signed [DATA_WIDTH-1:0] b_s;
  logic        [SHAMT_W-1:0]    shamt;

  assign a_s   = operand_a;
  assign b_s   = operand_b;
  assign shamt = operand_b[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    case (sel)
      ALU_ADD:       result = operand_a + operand_b;
      ALU_SUB:       result = operand_a - operand_b;
      ALU_AND:       result = operand_a & operand_b;
      ALU_OR:        result = operand_a | operand_b;
      ALU_XOR:       result = operand_a ^ operand_b;
      ALU_SLL:       result = operand_a << shamt;
      ALU_SLR:       result = operand_a >> shamt;
      ALU_SLT:       result = {{(DATA_WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU:      result = {{(DATA_WIDTH-1){1'b0}}, (operand_a < operand_b)};
      ALU_SRA:       result = a_s >>> shamt;
      ALU_OPERAND_B: result = operand_b;
      default:       result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one alu instance between two requesters (0 = execute stage,
//   1 = branch/AGU). Round-robin grant in IDLE, operation latched on the
//   handshake, executed in EXEC, result held in RESP until the owner takes it.
//   Ports:
//     clk, rst_n                       : clock, async active-low reset
//     reqN_valid/ready                 : operation handshake per requester
//     reqN_operand_a/operand_b/sel     : operation payload per requester
//     respN_valid/ready                : result handshake per requester
//     resp_result                      : registered result, shared by both
//     busy                             : FSM not in IDLE
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_operand_a,
  input  logic [DATA_WIDTH-1:0] req0_operand_b,
  input  logic [SEL_WIDTH-1:0]  req0_sel,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_operand_a,
  input  logic [DATA_WIDTH-1:0] req1_operand_b,
  input  logic [SEL_WIDTH-1:0]  req1_sel,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic                  busy
);

  // The wrapped alu is a fixed 32-bit datapath.
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("alu_arbiter: DATA_WIDTH must be 32");
  end

  arb_state_t state_q, state_d;
  req_id_t    prio_q, prio_d;

  logic                  grant_vld;
  req_id_t               grant_id;
  logic                  accept;
  logic                  resp_take;

  logic [DATA_WIDTH-1:0] op_a_p1;
  logic [DATA_WIDTH-1:0] op_b_p1;
  logic [SEL_WIDTH-1:0]  sel_p1;
  req_id_t               owner_p1;
  logic [DATA_WIDTH-1:0] alu_out;
  logic [DATA_WIDTH-1:0] result_p2;

  // Contention goes to the requester named by the pointer; otherwise the
  // single valid requester wins.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? prio_q : req1_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    accept      = 1'b0;
    resp_take   = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          accept     = 1'b1;
          req0_ready = (grant_id == 1'b0);
          req1_ready = (grant_id == 1'b1);
          state_d    = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        resp0_valid = (owner_p1 == 1'b0);
        resp1_valid = (owner_p1 == 1'b1);
        // Only the owner's ready matters; the other channel is ignored.
        resp_take   = owner_p1 ? resp1_ready : resp0_ready;
        if (resp_take) begin
          state_d = IDLE;
          prio_d  = ~owner_p1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // ---- stage p1: operation latched on the request handshake ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_p1  <= '0;
      op_b_p1  <= '0;
      sel_p1   <= '0;
      owner_p1 <= 1'b0;
    end else if (accept) begin
      op_a_p1  <= grant_id ? req1_operand_a : req0_operand_a;
      op_b_p1  <= grant_id ? req1_operand_b : req0_operand_b;
      sel_p1   <= grant_id ? req1_sel       : req0_sel;
      owner_p1 <= grant_id;
    end
  end

  alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_alu (
    .operand_a (op_a_p1),
    .operand_b (op_b_p1),
    .sel       (sel_p1),
    .result    (alu_out)
  );

  // ---- stage p2: result registered at the end of EXEC ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p2 <= '0;
    end else if (state_q == EXEC) begin
      result_p2 <= alu_out;
    end
  end

  assign resp_result = result_p2;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b;
  logic [3:0]  req0_sel, req1_sel;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] resp_result;
  logic        busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_prio = 1'b0;   // requester favoured on contention

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b), .req1_sel(req1_sel),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .busy(busy)
  );

  // Reference ALU from the arithmetic definition of each operation.
  function automatic logic [31:0] alu_ref(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, pw, q;
    int sh;
    sa = $signed(a); sb = $signed(b);
    ua = longint'(a); ub = longint'(b);
    sh = int'(b[4:0]);
    pw = longint'(1) << sh;
    case (sel)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return 32'(ua * pw);
      4'd6:  return 32'(ua / pw);
      4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd9:  begin
        q = sa / pw;
        if (sa < 0 && (sa % pw) != 0) q = q - 1;
        return 32'(q);
      end
      4'd15: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    req0_operand_a = 0; req0_operand_b = 0; req0_sel = 0;
    req1_operand_a = 0; req1_operand_b = 0; req1_sel = 0;
  endtask

  // Issues one op from requester id with resp_ready high; returns the result
  // and the number of cycles from the grant cycle to the response cycle.
  task automatic run_op(input logic id, input logic [3:0] sel, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output int lat,
                        output logic granted);
    int w;
    @(negedge clk);
    resp0_ready = 1; resp1_ready = 1;
    if (id) begin req1_valid = 1; req1_sel = sel; req1_operand_a = a; req1_operand_b = b; end
    else    begin req0_valid = 1; req0_sel = sel; req0_operand_a = a; req0_operand_b = b; end
    #1; w = 0;
    while (!(id ? req1_ready : req0_ready) && w < 20) begin @(negedge clk); #1; w++; end
    granted = id ? req1_ready : req0_ready;
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    lat = 1; #1;
    while (!(id ? resp1_valid : resp0_valid) && lat < 20) begin @(negedge clk); #1; lat++; end
    res = resp_result;
    if (lat < 20) exp_prio = ~id;
  endtask

  task automatic test_reset();
    rst_n = 0; clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if ({resp1_valid, resp0_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 00", {resp1_valid, resp0_valid}); end
    n_checks++; if (resp_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", resp_result); end
    @(negedge clk); rst_n = 1; exp_prio = 0;
  endtask

  task automatic test_single_op();
    @(negedge clk);
    req0_valid = 1; req0_sel = ALU_ADD; req0_operand_a = 32'h5; req0_operand_b = 32'h3;
    resp0_ready = 0; resp1_ready = 0;
    #1;
    n_checks++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b expected 01", {req1_ready, req0_ready}); end
    @(negedge clk); req0_valid = 0; #1;
    n_checks++; if ({busy, resp1_valid, resp0_valid} !== 3'b100) begin n_fail++; $display("FAIL single_exec: got %b expected 100", {busy, resp1_valid, resp0_valid}); end
    @(negedge clk); #1;
    n_checks++; if ({resp1_valid, resp0_valid} !== 2'b01) begin n_fail++; $display("FAIL single_resp_valid: got %b expected 01", {resp1_valid, resp0_valid}); end
    n_checks++; if (resp_result !== 32'h8) begin n_fail++; $display("FAIL single_result: got %h expected 00000008", resp_result); end
    resp0_ready = 1;
    @(negedge clk); #1;
    n_checks++; if ({busy, resp1_valid, resp0_valid} !== 3'b000) begin n_fail++; $display("FAIL single_done: got %b expected 000", {busy, resp1_valid, resp0_valid}); end
    resp0_ready = 0; exp_prio = 1;
  endtask

  task automatic test_contention();
    logic exp_win;
    rst_n = 0; clear_inputs();
    req0_sel = ALU_SUB; req0_operand_a = 32'd10; req0_operand_b = 32'd3;
    req1_sel = ALU_SLL; req1_operand_a = 32'd1;  req1_operand_b = 32'd4;
    req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
    @(negedge clk); @(negedge clk);
    rst_n = 1; exp_prio = 0; exp_win = 0;
    for (int g = 0; g < 3; g++) begin
      #1;
      n_checks++; if ({req1_ready, req0_ready} !== (exp_win ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL contention_grant%0d: got %b expected %b", g, {req1_ready, req0_ready}, exp_win ? 2'b10 : 2'b01); end
      @(negedge clk);
      @(negedge clk); #1;
      n_checks++; if ({resp1_valid, resp0_valid} !== (exp_win ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL contention_resp%0d: got %b expected %b", g, {resp1_valid, resp0_valid}, exp_win ? 2'b10 : 2'b01); end
      n_checks++; if (resp_result !== (exp_win ? 32'h10 : 32'h7)) begin n_fail++; $display("FAIL contention_result%0d: got %h expected %h", g, resp_result, exp_win ? 32'h10 : 32'h7); end
      exp_win = ~exp_win;
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    exp_prio = exp_win;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req1_valid = 1; req1_sel = ALU_SRA; req1_operand_a = 32'h8000_0000; req1_operand_b = 32'd4;
    resp1_ready = 0; resp0_ready = 1;
    #1;
    n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_grant: got %b expected 1", req1_ready); end
    @(negedge clk);
    req1_valid = 0; req0_valid = 1; req0_sel = ALU_ADD; req0_operand_a = 32'd1; req0_operand_b = 32'd2;
    @(negedge clk); #1;
    n_checks++; if (resp1_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resp_valid: got %b expected 1", resp1_valid); end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk); #1;
      n_checks++; if ({resp1_valid, resp0_valid, req0_ready} !== 3'b100) begin n_fail++; $display("FAIL bp_hold%0d: got %b expected 100", s, {resp1_valid, resp0_valid, req0_ready}); end
      n_checks++; if (resp_result !== 32'hF800_0000) begin n_fail++; $display("FAIL bp_result%0d: got %h expected f8000000", s, resp_result); end
    end
    resp1_ready = 1;
    @(negedge clk); #1;
    n_checks++; if ({busy, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got %b expected 01", {busy, req0_ready}); end
    exp_prio = 0;
    @(negedge clk); req0_valid = 0;
    @(negedge clk); #1;
    n_checks++; if ({resp0_valid, resp_result} !== {1'b1, 32'h3}) begin n_fail++; $display("FAIL bp_followup: got %b/%h expected 1/00000003", resp0_valid, resp_result); end
    exp_prio = 1;
  endtask

  task automatic test_compare();
    logic [31:0] res; int lat; logic g;
    run_op(1'b0, ALU_SLT, 32'hFFFF_FFFF, 32'd1, res, lat, g);
    n_checks++; if ({g, res} !== {1'b1, 32'h1}) begin n_fail++; $display("FAIL slt: got %b/%h expected 1/00000001", g, res); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL slt_latency: got %0d expected 2", lat); end
    run_op(1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, res, lat, g);
    n_checks++; if ({g, res} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL sltu: got %b/%h expected 1/00000000", g, res); end
    run_op(1'b0, 4'd12, 32'h1234_5678, 32'h9, res, lat, g);
    n_checks++; if ({g, res} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL undefined_sel: got %b/%h expected 1/00000000", g, res); end
  endtask

  task automatic test_wrap_passthru();
    logic [31:0] res; int lat; logic g;
    run_op(1'b0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, res, lat, g);
    n_checks++; if ({g, res} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL add_wrap: got %b/%h expected 1/00000000", g, res); end
    run_op(1'b1, ALU_OPERAND_B, 32'h1111_2222, 32'hDEAD_BEEF, res, lat, g);
    n_checks++; if ({g, res} !== {1'b1, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL operand_b: got %b/%h expected 1/deadbeef", g, res); end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    req0_valid = 1; req0_sel = ALU_ADD; req0_operand_a = 32'h100; req0_operand_b = 32'h23;
    resp0_ready = 1; resp1_ready = 1;
    @(negedge clk); req0_valid = 0; #1;
    n_checks++; if ({busy, resp_result} !== {1'b1, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL midrst_before: got %b/%h expected 1/deadbeef", busy, resp_result); end
    rst_n = 0; #1;
    n_checks++; if ({busy, resp1_valid, resp0_valid} !== 3'b000) begin n_fail++; $display("FAIL midrst_ctrl: got %b expected 000", {busy, resp1_valid, resp0_valid}); end
    n_checks++; if (resp_result !== 32'h0) begin n_fail++; $display("FAIL midrst_result: got %h expected 00000000", resp_result); end
    @(negedge clk); rst_n = 1; exp_prio = 0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk); #1;
      n_checks++; if ({busy, resp1_valid, resp0_valid} !== 3'b000) begin n_fail++; $display("FAIL midrst_after%0d: got %b expected 000", s, {busy, resp1_valid, resp0_valid}); end
    end
  endtask

  task automatic test_random();
    logic        both, single, exp_win;
    logic [3:0]  s0, s1;
    logic [31:0] a0, b0, a1, b1, exp_res;
    int          k;
    for (int it = 0; it < 40; it++) begin
      both = 1'($urandom_range(0, 1)); single = 1'($urandom_range(0, 1));
      s0 = 4'($urandom_range(0, 15)); s1 = 4'($urandom_range(0, 15));
      a0 = $urandom; a1 = $urandom;
      b0 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40);
      b1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40);
      k  = $urandom_range(0, 3);
      exp_win = both ? exp_prio : single;
      exp_res = exp_win ? alu_ref(s1, a1, b1) : alu_ref(s0, a0, b0);
      @(negedge clk);
      req0_sel = s0; req0_operand_a = a0; req0_operand_b = b0;
      req1_sel = s1; req1_operand_a = a1; req1_operand_b = b1;
      req0_valid = both | ~single; req1_valid = both | single;
      resp0_ready = 0; resp1_ready = 0;
      #1;
      n_checks++; if ({req1_ready, req0_ready} !== (exp_win ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rand_grant%0d: got %b expected %b", it, {req1_ready, req0_ready}, exp_win ? 2'b10 : 2'b01); end
      @(negedge clk); req0_valid = 0; req1_valid = 0; #1;
      n_checks++; if ({busy, resp1_valid, resp0_valid} !== 3'b100) begin n_fail++; $display("FAIL rand_exec%0d: got %b expected 100", it, {busy, resp1_valid, resp0_valid}); end
      @(negedge clk); #1;
      n_checks++; if ({resp1_valid, resp0_valid} !== (exp_win ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rand_resp%0d: got %b expected %b", it, {resp1_valid, resp0_valid}, exp_win ? 2'b10 : 2'b01); end
      n_checks++; if (resp_result !== exp_res) begin n_fail++; $display("FAIL rand_result%0d: sel %0d got %h expected %h", it, exp_win ? s1 : s0, resp_result, exp_res); end
      for (int s = 0; s < k; s++) begin
        if (exp_win) resp0_ready = 1'($urandom_range(0, 1)); else resp1_ready = 1'($urandom_range(0, 1));
        @(negedge clk); #1;
        n_checks++; if ({resp1_valid, resp0_valid, resp_result} !== {(exp_win ? 2'b10 : 2'b01), exp_res}) begin n_fail++; $display("FAIL rand_hold%0d: got %b/%h expected %b/%h", it, {resp1_valid, resp0_valid}, resp_result, exp_win ? 2'b10 : 2'b01, exp_res); end
      end
      if (exp_win) resp1_ready = 1; else resp0_ready = 1;
      exp_prio = ~exp_win;
    end
    @(negedge clk); clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_compare();
    test_wrap_passthru();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
